// File: rtl/cpu_defs.sv
// Shared CPU pipeline definitions: register-number width, mul/div counter
// width and the pipeline-control FSM state encoding.
package cpu_defs;

  localparam int REG_W = 5;
  localparam int CNT_W = 6;

  typedef logic [REG_W-1:0] reg_num_t;
  typedef logic [CNT_W-1:0] md_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_EXC     = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_md_timer.sv
// Loadable 6-bit down-counter timing a mul/div operation; saturates at zero
// and reports done while it holds zero.
module md_timer
  import cpu_defs::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  md_cnt_t load_val,
  input  logic    dec,
  input  logic    clear,
  output logic    done
);

  md_cnt_t count;

  // Abort (clear) beats a fresh load so an exception always wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - md_cnt_t'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller: load-use interlock, multi-cycle
// mul/div freeze and exception flush sequencing.
module pipe_ctrl
  import cpu_defs::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     id_valid,
  input  reg_num_t id_rs,
  input  reg_num_t id_rt,
  input  logic     id_use_rs,
  input  logic     id_use_rt,
  input  logic     ex_valid,
  input  logic     ex_load,
  input  reg_num_t ex_dest,
  input  logic     ex_md_start,
  input  logic     ex_md_div,
  input  logic     id_br_taken,
  input  logic     wb_exc,
  output logic     md_go,
  output logic     md_busy,
  output logic     stall_if,
  output logic     stall_id,
  output logic     stall_ex,
  output logic     flush_if,
  output logic     flush_id,
  output logic     flush_ex,
  output logic     flush_mem
);

  localparam md_cnt_t DIV_LOAD = md_cnt_t'(DIV_CYCLES - 1);
  localparam md_cnt_t MUL_LOAD = md_cnt_t'(MUL_CYCLES - 1);

  ctrl_state_t state, state_next;
  logic        load_use;
  logic        md_req;
  logic        timer_done;
  logic        timer_dec;

  assign load_use = ex_valid && ex_load && id_valid && (ex_dest != '0) &&
                    ((id_use_rs && (id_rs == ex_dest)) ||
                     (id_use_rt && (id_rt == ex_dest)));
  assign md_req    = ex_valid && ex_md_start;
  assign timer_dec = (state == ST_MD_BUSY) && !wb_exc;

  md_timer u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (md_go),
    .load_val (ex_md_div ? DIV_LOAD : MUL_LOAD),
    .dec      (timer_dec),
    .clear    (wb_exc),
    .done     (timer_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // wb_exc overrides everything; a start request seen in EXC is already flushed.
  always_comb begin
    state_next = state;
    if (wb_exc) begin
      state_next = ST_EXC;
    end else begin
      unique case (state)
        ST_IDLE:    if (md_req) state_next = ST_MD_BUSY;
        ST_MD_BUSY: if (timer_done) state_next = ST_IDLE;
        ST_EXC:     state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    md_go     = 1'b0;
    md_busy   = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    if (!reset || wb_exc || (state == ST_EXC)) begin
      flush_if  = 1'b1;
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (state == ST_MD_BUSY) begin
      md_busy  = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
    end else begin
      md_go    = md_req;
      stall_if = load_use;
      stall_id = load_use;
      flush_ex = load_use;
      // A taken branch stuck behind a stalled ID is retried once ID moves on.
      flush_if = id_br_taken && !load_use;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_pipe_ctrl;

  localparam int DIV_N = 32;
  localparam int MUL_N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt, ex_dest;
  logic       ex_valid, ex_load, ex_md_start, ex_md_div, id_br_taken, wb_exc;
  logic       md_go, md_busy, stall_if, stall_id, stall_ex;
  logic       flush_if, flush_id, flush_ex, flush_mem;

  int errors = 0;
  int checks = 0;

  int m_busy_left = 0;
  bit m_exc = 1'b0;

  pipe_ctrl #(.DIV_CYCLES(DIV_N), .MUL_CYCLES(MUL_N)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_valid    (ex_valid),
    .ex_load     (ex_load),
    .ex_dest     (ex_dest),
    .ex_md_start (ex_md_start),
    .ex_md_div   (ex_md_div),
    .id_br_taken (id_br_taken),
    .wb_exc      (wb_exc),
    .md_go       (md_go),
    .md_busy     (md_busy),
    .stall_if    (stall_if),
    .stall_id    (stall_id),
    .stall_ex    (stall_ex),
    .flush_if    (flush_if),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .flush_mem   (flush_mem)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs {md_go, md_busy, stall_if/id/ex, flush_if/id/ex/mem}.
  function automatic logic [8:0] model_out();
    logic haz;
    haz = ex_valid && ex_load && id_valid && (ex_dest != 5'd0) &&
          ((id_use_rs && (id_rs == ex_dest)) || (id_use_rt && (id_rt == ex_dest)));
    if (!reset || wb_exc || m_exc) return 9'b00000_1111;
    if (m_busy_left > 0)           return 9'b01111_0000;
    return {ex_valid && ex_md_start, 1'b0, haz, haz, 1'b0,
            id_br_taken && !haz, 1'b0, haz, 1'b0};
  endfunction

  // The model counts remaining frozen-EX cycles rather than tracking a state.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy_left <= 0;
      m_exc       <= 1'b0;
    end else if (wb_exc) begin
      m_busy_left <= 0;
      m_exc       <= 1'b1;
    end else if (m_exc) begin
      m_exc <= 1'b0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
    end else if (ex_valid && ex_md_start) begin
      m_busy_left <= ex_md_div ? DIV_N : MUL_N;
    end
  end

  always @(negedge clk) begin
    check_output("cycle_outputs",
                 int'({md_go, md_busy, stall_if, stall_id, stall_ex,
                       flush_if, flush_id, flush_ex, flush_mem}),
                 int'(model_out()));
  end

  task automatic apply_stimulus();
    id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_dest = 5'd0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_md_start = 1'b0; ex_md_div = 1'b0;
    id_br_taken = 1'b0; wb_exc = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_valid = 1'b1; ex_load = 1'b1; ex_dest = r;
    id_valid = 1'b1; id_rs = r; id_use_rs = 1'b1;
  endtask

  // Starts a mul/div and counts stall_ex cycles until the controller idles.
  task automatic run_md(input logic is_div, input int exp_len, input string tag);
    int stall_cnt;
    int idle_at;
    next_cycle();
    apply_stimulus();
    ex_valid = 1'b1; ex_md_start = 1'b1; ex_md_div = is_div;
    @(negedge clk);
    check_output({tag, "_go"}, md_go, 1);
    check_output({tag, "_go_stall_ex"}, stall_ex, 0);
    stall_cnt = 0;
    idle_at = 0;
    for (int i = 1; i <= exp_len + 8 && idle_at == 0; i++) begin
      next_cycle();
      if (i == 5) set_load_use(5'd8);
      if (i == 6) begin ex_load = 1'b0; id_valid = 1'b0; end
      if (i == exp_len / 2) ex_md_start = 1'b0;
      @(negedge clk);
      if (i == 5 && exp_len > 5) begin
        check_output({tag, "_hazard_flush_ex"}, flush_ex, 0);
        check_output({tag, "_hazard_stall_id"}, stall_id, 1);
      end
      if (stall_ex) stall_cnt++;
      else idle_at = i;
    end
    check_output({tag, "_stall_cycles"}, stall_cnt, exp_len);
    check_output({tag, "_idle_cycle"}, idle_at, exp_len + 1);
  endtask

  initial begin
    apply_stimulus();
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_flush_if", flush_if, 1);
    check_output("reset_flush_mem", flush_mem, 1);
    check_output("reset_stall_if", stall_if, 0);
    check_output("reset_md_busy", md_busy, 0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_output("idle_flush_if", flush_if, 0);

    // Load-use on rs, then the load moves to MEM.
    next_cycle(); apply_stimulus(); set_load_use(5'd8);
    @(negedge clk);
    check_output("lu_stall_if", stall_if, 1);
    check_output("lu_flush_ex", flush_ex, 1);
    next_cycle(); ex_load = 1'b0;
    @(negedge clk);
    check_output("lu_released", stall_if, 0);

    // Load-use on rt; rs match ignored when not used; $0 never hazards.
    next_cycle(); apply_stimulus();
    ex_valid = 1'b1; ex_load = 1'b1; ex_dest = 5'd9;
    id_valid = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    @(negedge clk);
    check_output("lu_rt_stall_id", stall_id, 1);
    next_cycle(); id_use_rt = 1'b0; id_rs = 5'd9;
    @(negedge clk);
    check_output("lu_unused_rs", stall_id, 0);
    next_cycle(); apply_stimulus(); set_load_use(5'd0);
    @(negedge clk);
    check_output("lu_zero_reg", stall_if, 0);

    // Taken branch deferred behind a load-use stall.
    next_cycle(); apply_stimulus(); set_load_use(5'd3); id_br_taken = 1'b1;
    @(negedge clk);
    check_output("br_deferred", flush_if, 0);
    next_cycle(); ex_load = 1'b0;
    @(negedge clk);
    check_output("br_flush", flush_if, 1);

    // Start request without ex_valid is ignored.
    next_cycle(); apply_stimulus(); ex_md_start = 1'b1; ex_md_div = 1'b1;
    @(negedge clk);
    check_output("md_invalid_go", md_go, 0);

    run_md(1'b1, DIV_N, "div");
    run_md(1'b0, MUL_N, "mul");

    // Exception on the 10th busy cycle of a divide.
    next_cycle(); apply_stimulus(); ex_valid = 1'b1; ex_md_start = 1'b1; ex_md_div = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      next_cycle(); ex_md_start = 1'b0;
      if (i == 10) wb_exc = 1'b1;
    end
    @(negedge clk);
    check_output("exc_flush_mem", flush_mem, 1);
    check_output("exc_md_busy", md_busy, 0);
    check_output("exc_stall_ex", stall_ex, 0);
    next_cycle(); wb_exc = 1'b0;
    @(negedge clk);
    check_output("exc_tail_flush_id", flush_id, 1);
    check_output("exc_tail_stall_if", stall_if, 0);
    next_cycle();
    @(negedge clk);
    check_output("exc_after_flush_if", flush_if, 0);
    check_output("exc_after_md_busy", md_busy, 0);

    // Back-to-back exceptions restart EXC; exception beats a start request.
    next_cycle(); apply_stimulus(); wb_exc = 1'b1;
    next_cycle();
    next_cycle(); wb_exc = 1'b0;
    @(negedge clk);
    check_output("exc_restart_tail", flush_mem, 1);
    next_cycle();
    @(negedge clk);
    check_output("exc_restart_done", flush_mem, 0);
    next_cycle(); wb_exc = 1'b1; ex_valid = 1'b1; ex_md_start = 1'b1;
    @(negedge clk);
    check_output("exc_blocks_go", md_go, 0);
    next_cycle(); apply_stimulus();
    next_cycle();
    @(negedge clk);
    check_output("exc_no_busy", md_busy, 0);

    // Reset while the divide counter sits at 5, then no restart on release.
    next_cycle(); apply_stimulus(); ex_valid = 1'b1; ex_md_start = 1'b1; ex_md_div = 1'b1;
    for (int i = 1; i <= DIV_N - 5; i++) begin
      next_cycle(); ex_md_start = 1'b0;
    end
    reset = 1'b0;
    #1;
    check_output("rst_busy_md_busy", md_busy, 0);
    check_output("rst_busy_flush_ex", flush_ex, 1);
    check_output("rst_busy_stall_ex", stall_ex, 0);
    next_cycle();
    next_cycle(); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_release_go", md_go, 0);
      check_output("rst_release_busy", md_busy, 0);
      next_cycle();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
